i2s_rx_frontend: RTL and testbench
==================================

Name: i2s_rx_frontend

Overview:
- Upstream stage of the FIR/IIR filter chain: deserialises a standard I2S stream (Philips format, MSB first, one-bit delay after LRCLK edge) into signed parallel samples.
- Runs in the system clock domain; oversamples the external SCLK/LRCLK/SDATA pins.
- Presents a left/right pair plus a selected mono channel, held stable between updates, as the filter's data_in source.

Parameters:
- WD, 24, sample width in bits; matches the filter WD_IN.
- SLOT_BITS, 32, expected SCLK cycles per channel slot; must be >= WD.
- CNT_W, 6, bit-counter width; must satisfy 2**CNT_W > SLOT_BITS.

Ports:
- clk  in  1  system clock; must run at >= 4x SCLK frequency.
- reset_n  in  1  asynchronous active-low reset.
- i2s_sclk  in  1  bit clock, asynchronous to clk.
- i2s_lrclk  in  1  word select, asynchronous to clk; 0 = left, 1 = right.
- i2s_sdata  in  1  serial data, asynchronous to clk.
- mono_sel  in  1  0 drives data_out from left, 1 from right; quasi-static.
- err_clr  in  1  synchronous one-cycle clear of frame_err.
- sample_l  out  WD  signed left sample.
- sample_r  out  WD  signed right sample.
- data_out  out  WD  signed mono sample; feeds the filter data_in.
- sample_valid  out  1  one-clk pulse when a new L/R pair is committed.
- frame_err  out  1  sticky slot-length error flag.

Behaviour:
- Synchronisation:
  - sclk, lrclk and sdata each pass through a 2-FF synchroniser, so all three have equal delay.
  - A third sclk register detects rising edges: sclk_rise = s2 & ~s3.
  - All state below advances only on cycles where sclk_rise = 1.
- Slot tracking:
  - lr_prev holds lrclk as sampled at the previous sclk_rise.
  - A transition is lrclk != lr_prev at an sclk_rise. This edge is the I2S delay bit, and its sdata is discarded.
  - On a transition:
    - bit_cnt <= 0.
    - Commit the finished slot (see Commit).
    - shift_reg <= 0.
    - armed <= 1.
  - On a non-transition rise:
    - If bit_cnt < WD: shift_reg <= {shift_reg[WD-2:0], sdata}.
    - bit_cnt increments and saturates at 2**CNT_W-1. Bits beyond WD are ignored.
- Commit:
  - Happens only if armed was already 1 at the transition. The first partial slot after reset is therefore discarded.
  - Committed value = shift_reg << (WD - min(bit_cnt, WD)). Short slots are left-justified and zero-padded in the LSBs.
  - Ending slot was left (lr_prev = 0): write the value to hold_l (internal only).
  - Ending slot was right (lr_prev = 1):
    - sample_l <= hold_l and sample_r <= committed value, in the same clk.
    - sample_valid pulses high for exactly one clk.
  - The pair is always updated atomically. A right slot with no preceding committed left after arming produces no pulse.
- Frame error:
  - At every armed transition, if (bit_cnt + 1) != SLOT_BITS, set frame_err. The +1 accounts for the delay bit.
  - The affected sample is still committed.
  - err_clr clears frame_err. If a set and a clear occur in the same cycle, set wins.
- Output mux:
  - data_out = mono_sel ? sample_r : sample_l. Registered: updates one clk after sample_l/sample_r.
- Latency: sclk rising pin edge to sclk_rise = 3 clk. The final right-slot transition edge to sample_valid = 4 clk. data_out follows 1 clk later.
- Reset (any time, including mid-slot):
  - All outputs go to 0; sample_valid = 0, frame_err = 0.
  - armed = 0, bit_cnt = 0, shift_reg = 0.
  - lr_prev reloads from the synchronised lrclk at the first sclk_rise after release, with no transition reported.
- SCLK stopped: no state change; outputs hold indefinitely.

Decomposition:
- Shared package filt_pkg:
  - typedef sample_t = logic signed [WD-1:0], shared with the FIR/IIR stages.
  - Constants I2S_LEFT = 1'b0 and I2S_RIGHT = 1'b1.
- Sub-module sync_2ff (parameterised width, async active-low reset). Instantiated once, 3 bits wide, for sclk/lrclk/sdata; reusable by other pin-facing blocks.

Test Plan:
- Nominal stereo: clk = 8x SCLK, 32-bit slots, L = 24'h123456, R = 24'hFEDCBA. Expect:
  - The first frame after reset is discarded.
  - From the second complete frame, sample_valid pulses once per frame with sample_l = 24'h123456 and sample_r = 24'hFEDCBA.
  - data_out = 24'h123456 with mono_sel = 0, and 24'hFEDCBA after switching to mono_sel = 1.
  - frame_err = 0.
- Short slot: 16-bit slots carrying L = 16'h8001. Expect:
  - sample_l = 24'h800100 (zero-padded LSBs).
  - frame_err = 1.
  - err_clr for one cycle returns frame_err to 0; it re-sets at the next transition.
- Long slot: 40-bit slots, first 24 bits = 24'h7FFFFF, then 16 ones. Expect sample = 24'h7FFFFF and frame_err = 1.
- Reset mid-slot: assert reset_n low for 3 clk during bit 10 of a left slot. Expect:
  - All outputs are 0 immediately (asynchronously).
  - No sample_valid until one full L+R pair completes after the next transition.
- Synchroniser/latency: measure from the pin edge of the final right-slot transition to sample_valid. Expect exactly 4 clk (±1 clk for phase alignment), with sample_valid exactly 1 clk wide.
- SCLK stall: hold SCLK low for 1000 clk mid-frame. Expect:
  - Outputs unchanged and no pulse during the stall.
  - On resume, the frame completes with the correct values.

Source files
------------

// File: rtl/filt_pkg.sv
// Shared types and constants for the audio filter chain (I2S front end, FIR/IIR stages).
package filt_pkg;

  localparam int WD_DEF = 24;

  typedef logic signed [WD_DEF-1:0] sample_t;

  localparam logic I2S_LEFT  = 1'b0;
  localparam logic I2S_RIGHT = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pin inputs; every bit sees the same delay.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  // metastability filter: two back-to-back stages
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= {W{1'b0}};
      r_s2 <= {W{1'b0}};
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/i2s_rx_frontend.sv
// Philips I2S receiver: oversamples SCLK/LRCLK/SDATA in the system clock domain and
// presents committed left/right pairs plus a selected mono channel to the filter chain.
module i2s_rx_frontend
  import filt_pkg::*;
#(
  parameter int WD        = 24,
  parameter int SLOT_BITS = 32,
  parameter int CNT_W     = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i2s_sclk,
  input  logic                 i2s_lrclk,
  input  logic                 i2s_sdata,
  input  logic                 mono_sel,
  input  logic                 err_clr,
  output logic signed [WD-1:0] sample_l,
  output logic signed [WD-1:0] sample_r,
  output logic signed [WD-1:0] data_out,
  output logic                 sample_valid,
  output logic                 frame_err
);

  localparam logic [CNT_W-1:0] WD_C    = CNT_W'(WD);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   SLOT_C  = (CNT_W+1)'(SLOT_BITS);

  logic [2:0]          w_pins_s;
  logic                w_sclk_s;
  logic                w_lrclk_s;
  logic                w_sdata_s;
  logic                w_sclk_rise;

  logic                r_sclk_d;
  logic                r_lr_init;
  logic                r_lr_prev;
  logic                r_armed;
  logic                r_have_l;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [WD-1:0]       r_shift;
  logic [WD-1:0]       r_hold_l;
  logic [WD-1:0]       r_sample_l;
  logic [WD-1:0]       r_sample_r;
  logic [WD-1:0]       r_data_out;
  logic                r_valid;
  logic                r_err;

  logic [CNT_W-1:0]    w_fill;
  logic [CNT_W-1:0]    w_shamt;
  logic [WD-1:0]       w_commit;
  logic [CNT_W:0]      w_slot_len;
  logic                w_len_bad;

  sync_2ff #(.W(3)) u_sync (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_d     ({i2s_sdata, i2s_lrclk, i2s_sclk}),
    .o_q     (w_pins_s)
  );

  assign w_sclk_s    = w_pins_s[0];
  assign w_lrclk_s   = w_pins_s[1];
  assign w_sdata_s   = w_pins_s[2];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;

  // left-justify a finished slot and measure its length including the delay bit
  always_comb begin
    w_fill     = (r_bit_cnt < WD_C) ? r_bit_cnt : WD_C;
    w_shamt    = WD_C - w_fill;
    w_commit   = r_shift << w_shamt;
    w_slot_len = {1'b0, r_bit_cnt} + {{CNT_W{1'b0}}, 1'b1};
    w_len_bad  = (w_slot_len != SLOT_C);
  end

  // slot tracking, commit and output registers, all advanced on synchronised sclk rises
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_d   <= 1'b0;
      r_lr_init  <= 1'b0;
      r_lr_prev  <= I2S_LEFT;
      r_armed    <= 1'b0;
      r_have_l   <= 1'b0;
      r_bit_cnt  <= {CNT_W{1'b0}};
      r_shift    <= {WD{1'b0}};
      r_hold_l   <= {WD{1'b0}};
      r_sample_l <= {WD{1'b0}};
      r_sample_r <= {WD{1'b0}};
      r_data_out <= {WD{1'b0}};
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_sclk_d   <= w_sclk_s;
      r_valid    <= 1'b0;
      r_data_out <= mono_sel ? r_sample_r : r_sample_l;
      if (err_clr) begin
        r_err <= 1'b0;
      end
      if (w_sclk_rise) begin
        if (!r_lr_init) begin
          // first rise after reset only learns the current word-select level
          r_lr_init <= 1'b1;
          r_lr_prev <= w_lrclk_s;
        end else if (w_lrclk_s != r_lr_prev) begin
          r_lr_prev <= w_lrclk_s;
          r_bit_cnt <= {CNT_W{1'b0}};
          r_shift   <= {WD{1'b0}};
          r_armed   <= 1'b1;
          if (r_armed) begin
            if (w_len_bad) begin
              r_err <= 1'b1;
            end
            if (r_lr_prev == I2S_LEFT) begin
              r_hold_l <= w_commit;
              r_have_l <= 1'b1;
            end else begin
              r_have_l <= 1'b0;
              if (r_have_l) begin
                r_sample_l <= r_hold_l;
                r_sample_r <= w_commit;
                r_valid    <= 1'b1;
              end
            end
          end
        end else begin
          if (r_bit_cnt < WD_C) begin
            r_shift <= {r_shift[WD-2:0], w_sdata_s};
          end
          if (r_bit_cnt != CNT_MAX) begin
            r_bit_cnt <= r_bit_cnt + CNT_ONE;
          end
        end
      end
    end
  end

  assign sample_l     = r_sample_l;
  assign sample_r     = r_sample_r;
  assign data_out     = r_data_out;
  assign sample_valid = r_valid;
  assign frame_err    = r_err;

endmodule

// File: tb/tb_i2s_rx_frontend.sv
// Self-checking bench for i2s_rx_frontend: an I2S transmitter driven at 8 clk per SCLK
// and a slot-level reference model predicting every committed pair.
module tb_i2s_rx_frontend;

  localparam int WD        = 24;
  localparam int SLOT_BITS = 32;

  logic clk       = 1'b0;
  logic reset_n   = 1'b0;
  logic i2s_sclk  = 1'b0;
  logic i2s_lrclk = 1'b1;
  logic i2s_sdata = 1'b0;
  logic mono_sel  = 1'b0;
  logic err_clr   = 1'b0;
  logic signed [WD-1:0] sample_l;
  logic signed [WD-1:0] sample_r;
  logic signed [WD-1:0] data_out;
  logic sample_valid;
  logic frame_err;

  i2s_rx_frontend #(.WD(WD), .SLOT_BITS(SLOT_BITS), .CNT_W(6)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i2s_sclk     (i2s_sclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .mono_sel     (mono_sel),
    .err_clr      (err_clr),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .data_out     (data_out),
    .sample_valid (sample_valid),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WD-1:0] l;
    logic [WD-1:0] r;
    int            stamp;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // reference model state (slot level)
  bit            m_armed = 1'b0;
  bit            m_have  = 1'b0;
  bit            m_err   = 1'b0;
  bit            m_fresh = 1'b1;
  logic [WD-1:0] m_hold  = '0;
  bit            cur_bits[$];
  int            cur_n   = 0;
  logic          cur_ch  = 1'b0;
  bit            pend    = 1'b0;
  logic [WD-1:0] pend_l  = '0;
  logic [WD-1:0] pend_r  = '0;
  logic [WD-1:0] chk_l   = '0;
  logic [WD-1:0] chk_r   = '0;
  logic          chk_e   = 1'b0;

  // compare-process expectations
  logic [WD-1:0] e_l = '0;
  logic [WD-1:0] e_r = '0;
  logic [WD-1:0] p_l = '0;
  logic [WD-1:0] p_r = '0;
  logic          p_m = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [WD-1:0] act, input logic [WD-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (!reset_n) begin
      check("reset_sample_l", sample_l, '0);
      check("reset_sample_r", sample_r, '0);
      check("reset_data_out", data_out, '0);
      check1("reset_valid", sample_valid, 1'b0);
      check1("reset_frame_err", frame_err, 1'b0);
      e_l = '0; e_r = '0; p_l = '0; p_r = '0; p_m = mono_sel;
    end else begin
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_pulse: got sample_valid=1 expected 0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          int   lat;
          e   = exp_q.pop_front();
          lat = cyc - e.stamp;
          n_vec++;
          if (lat < 3 || lat > 5) begin
            n_bad++;
            $display("FAIL latency: got %0d clk expected 4+-1 clk", lat);
          end
          e_l = e.l;
          e_r = e.r;
        end
      end
      check("sample_l", sample_l, e_l);
      check("sample_r", sample_r, e_r);
      check("data_out", data_out, p_m ? p_r : p_l);
      p_l = e_l; p_r = e_r; p_m = mono_sel;
    end
  end

  task automatic model_reset();
    m_armed = 1'b0; m_have = 1'b0; m_err = 1'b0; m_fresh = 1'b1;
    pend = 1'b0;
    exp_q.delete();
    cur_bits.delete();
  endtask

  // a word-select change ends the current slot: commit it if armed, then start a new one
  task automatic model_boundary(input logic ch, input int n);
    logic [WD-1:0] v;
    v = '0;
    for (int i = 0; i < WD; i++)
      if (i < cur_bits.size()) v[WD-1-i] = cur_bits[i];
    if (m_armed) begin
      if (cur_n != SLOT_BITS) m_err = 1'b1;
      if (cur_ch == 1'b0) begin
        m_hold = v;
        m_have = 1'b1;
      end else begin
        if (m_have) begin
          pend   = 1'b1;
          pend_l = m_hold;
          pend_r = v;
        end
        m_have = 1'b0;
      end
    end
    m_armed = 1'b1;
    cur_ch  = ch;
    cur_n   = n;
    cur_bits.delete();
  endtask

  task automatic do_act(input int act);
    if (act == 1) begin
      @(posedge clk); #1;
      reset_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
    end else if (act == 2) begin
      repeat (1000) @(posedge clk);
      #1;
    end else if (act == 3 || act == 7) begin
      if (act == 7) begin
        check("short_l", sample_l, chk_l);
        check("short_r", sample_r, chk_r);
        check1("short_err", frame_err, chk_e);
      end
      @(posedge clk); #1;
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      m_err   = 1'b0;
      @(posedge clk); #1;
      check1("err_cleared", frame_err, 1'b0);
    end else if (act == 4 || act == 6) begin
      check("pinned_l", sample_l, chk_l);
      check("pinned_r", sample_r, chk_r);
      check1("pinned_err", frame_err, chk_e);
      if (act == 6) begin
        check("mono_left", data_out, chk_l);
        mono_sel = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mono_right", data_out, chk_r);
        mono_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
    end else if (act == 5) begin
      check1("model_err", frame_err, m_err);
    end else if (act == 8) begin
      check1("err_reset", frame_err, 1'b1);
    end
  endtask

  // one SCLK period: data and word select change with SCLK low, receiver samples on the rise
  task automatic sclk_bit(input logic lr, input logic sd, input int act);
    i2s_sclk  = 1'b0;
    i2s_lrclk = lr;
    i2s_sdata = sd;
    if (act != 0) do_act(act);
    repeat (4) @(posedge clk);
    #1;
    i2s_sclk = 1'b1;
    if (pend) begin
      exp_q.push_back('{pend_l, pend_r, cyc});
      pend = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // n SCLKs at level ch: delay bit, then word MSB first, then filler
  task automatic send_slot(input logic ch, input int n, input logic [WD-1:0] word,
                           input int wbits, input bit ones, input int act, input int at);
    for (int k = 1; k <= n; k++) begin
      logic sd;
      if (k == 1) begin
        sd = 1'($urandom_range(0, 1));
        if (!m_fresh) model_boundary(ch, n);
      end else begin
        if (k - 2 < wbits) sd = word[WD-1-(k-2)];
        else if (ones)     sd = 1'b1;
        else               sd = 1'($urandom_range(0, 1));
        cur_bits.push_back(sd);
      end
      sclk_bit(ch, sd, (k == at) ? act : 0);
      m_fresh = 1'b0;
    end
  endtask

  initial begin
    int lens[7];
    lens = '{32, 32, 32, 17, 40, 30, 24};
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // partial slot after reset, then nominal stereo frames
    send_slot(1'b1, 5, '0, 0, 1'b0, 0, 0);
    for (int f = 0; f < 4; f++) begin
      send_slot(1'b0, 32, 24'h123456, 24, 1'b0, 0, 0);
      send_slot(1'b1, 32, 24'hFEDCBA, 24, 1'b0, 0, 0);
    end
    chk_l = 24'h123456; chk_r = 24'hFEDCBA; chk_e = 1'b0;
    send_slot(1'b0, 32, 24'h123456, 24, 1'b0, 6, 4);
    send_slot(1'b1, 32, 24'hFEDCBA, 24, 1'b0, 0, 0);

    // short slots: 17 SCLKs = delay bit + 16 data bits
    send_slot(1'b0, 17, 24'h800100, 16, 1'b0, 0, 0);
    send_slot(1'b1, 17, 24'hABCD00, 16, 1'b0, 0, 0);
    chk_l = 24'h800100; chk_r = 24'hABCD00; chk_e = 1'b1;
    send_slot(1'b0, 17, 24'h800100, 16, 1'b0, 7, 8);
    send_slot(1'b1, 32, 24'h00FF00, 24, 1'b0, 8, 4);

    // long slot: 24 data bits followed by ones
    send_slot(1'b0, 40, 24'h7FFFFF, 24, 1'b1, 3, 30);
    send_slot(1'b1, 32, 24'h000001, 24, 1'b0, 0, 0);
    chk_l = 24'h7FFFFF; chk_r = 24'h000001; chk_e = 1'b1;
    send_slot(1'b0, 32, 24'h135790, 24, 1'b0, 4, 10);

    // SCLK stall mid-frame
    send_slot(1'b1, 32, 24'h0F0F0F, 24, 1'b0, 0, 0);
    send_slot(1'b0, 32, 24'h2468AC, 24, 1'b0, 2, 15);
    send_slot(1'b1, 32, 24'hC0FFEE, 24, 1'b0, 0, 0);
    chk_l = 24'h2468AC; chk_r = 24'hC0FFEE; chk_e = 1'b1;
    send_slot(1'b0, 32, 24'h111111, 24, 1'b0, 4, 10);

    // reset in the middle of a left slot
    send_slot(1'b1, 32, 24'h222222, 24, 1'b0, 0, 0);
    send_slot(1'b0, 32, 24'h333333, 24, 1'b0, 1, 11);
    send_slot(1'b1, 32, 24'h444444, 24, 1'b0, 0, 0);
    send_slot(1'b0, 32, 24'h555555, 24, 1'b0, 0, 0);
    send_slot(1'b1, 32, 24'h666666, 24, 1'b0, 0, 0);
    chk_l = 24'h555555; chk_r = 24'h666666; chk_e = 1'b0;
    send_slot(1'b0, 32, 24'h777777, 24, 1'b0, 4, 10);
    send_slot(1'b1, 32, 24'h888888, 24, 1'b0, 0, 0);

    // randomized frames: random words, slot lengths and mono selection
    for (int f = 0; f < 10; f++) begin
      mono_sel = 1'($urandom_range(0, 1));
      send_slot(1'b0, lens[$urandom_range(0, 6)], WD'($urandom), 24, 1'b0, 0, 0);
      send_slot(1'b1, lens[$urandom_range(0, 6)], WD'($urandom), 24, 1'b0, 0, 0);
    end
    send_slot(1'b0, 32, 24'h000000, 24, 1'b0, 5, 10);

    repeat (20) @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_pulses: got %0d outstanding expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
